// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sequence detector.
// The functions are only ever evaluated on constants to build lookup tables.
package seq_det_pkg;

    typedef enum logic {
        OUT_MEALY,
        OUT_MOORE
    } out_mode_e;

    localparam int MAX_PAT_W = 16;

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border_len(logic [MAX_PAT_W-1:0] pattern, int width);
        int  best;
        bit  ok;
        best = 0;
        for (int k = 1; k < width; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (pattern[width-1-i] != pattern[k-1-i]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Progress after appending bit b to a history whose matched prefix length is p.
    function automatic int next_prog(logic [MAX_PAT_W-1:0] pattern, int width, int p, logic b);
        logic [MAX_PAT_W:0] seq;
        int                 best;
        bit                 ok;
        seq  = '0;
        best = 0;
        for (int j = 0; j < p; j++) seq[j] = pattern[width-1-j];
        seq[p] = b;
        for (int k = 1; k <= p + 1; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (seq[p+1-k+i] != pattern[width-1-i]) ok = 1'b0;
            end
            if (ok && k <= width) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
        sat_d = &count_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: progress register walks a constant prefix-match table,
// with selectable Mealy/Moore output, overlap policy and a saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               MOORE   = 0,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8,
    parameter int               ST_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             xin,
    input  logic             in_valid,
    input  logic             clear,
    output logic             y_out,
    output logic [ST_W-1:0]  new_state,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam logic [MAX_PAT_W-1:0] PAT16   = MAX_PAT_W'(PATTERN);
    localparam int                   BORDER  = border_len(PAT16, PAT_W);
    localparam logic [ST_W-1:0]      RESTART = (OVERLAP != 0) ? ST_W'(BORDER) : '0;
    localparam logic [ST_W-1:0]      FULL    = ST_W'(PAT_W);
    localparam out_mode_e            MODE    = (MOORE != 0) ? OUT_MOORE : OUT_MEALY;
    localparam int                   TBL_N   = 2 ** (ST_W + 1);

    // Indexed by {progress, bit}; entries for unreachable progress values are never selected.
    logic [ST_W-1:0] nxt_tbl [TBL_N];

    for (genvar e = 0; e < TBL_N; e++) begin : g_tbl
        localparam int   P = e / 2;
        localparam logic B = logic'(e % 2);
        if (P < PAT_W) begin : g_live
            assign nxt_tbl[e] = ST_W'(next_prog(PAT16, PAT_W, P, B));
        end else begin : g_dead
            assign nxt_tbl[e] = '0;
        end
    end

    logic [ST_W-1:0] prog_q, prog_d;
    logic            moore_q, moore_d;
    logic [ST_W-1:0] cand;
    logic            step;
    logic            match;

    assign cand  = nxt_tbl[{prog_q, xin}];
    assign step  = in_valid && !clear;
    assign match = step && (cand == FULL);

    always_comb begin
        prog_d  = prog_q;
        moore_d = 1'b0;
        if (clear) begin
            prog_d = '0;
        end else if (in_valid) begin
            prog_d  = match ? RESTART : cand;
            moore_d = match;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prog_q  <= '0;
            moore_q <= 1'b0;
        end else begin
            prog_q  <= prog_d;
            moore_q <= moore_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (match),
        .clr  (clear),
        .count(match_count),
        .sat  (count_sat)
    );

    assign y_out     = (MODE == OUT_MOORE) ? moore_q : match;
    assign new_state = prog_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives four detector configurations from one shared stream and compares each
// against a bit-history model of the pattern-matching rules.
module tb_seq_detector_param;

    localparam int PAT   = 4'b1011;
    localparam int PLEN  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       xin = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;

    logic       ya, yb, yc, yd;
    logic [2:0] sa, sb, sc, sd;
    logic [7:0] ca, cb, cc;
    logic [1:0] cd;
    logic       za, zb, zc, zd;

    int assertCount = 0;
    int failCount   = 0;

    // Model configuration: 0 default, 1 non-overlap, 2 Moore, 3 two-bit counter.
    int overlapCfg [4] = '{1, 0, 1, 1};
    int cntMax     [4] = '{255, 255, 255, 3};
    int histBits   [4];
    int histLen    [4];
    int cnt        [4];
    int mooreFlag  [4];

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk(clk), .reset(reset), .xin(xin), .in_valid(in_valid), .clear(clear),
        .y_out(ya), .new_state(sa), .match_count(ca), .count_sat(za)
    );

    seq_detector_param #(.OVERLAP(0)) dut_b (
        .clk(clk), .reset(reset), .xin(xin), .in_valid(in_valid), .clear(clear),
        .y_out(yb), .new_state(sb), .match_count(cb), .count_sat(zb)
    );

    seq_detector_param #(.MOORE(1)) dut_c (
        .clk(clk), .reset(reset), .xin(xin), .in_valid(in_valid), .clear(clear),
        .y_out(yc), .new_state(sc), .match_count(cc), .count_sat(zc)
    );

    seq_detector_param #(.CNT_W(2)) dut_d (
        .clk(clk), .reset(reset), .xin(xin), .in_valid(in_valid), .clear(clear),
        .y_out(yd), .new_state(sd), .match_count(cd), .count_sat(zd)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int modelProg(input int i);
        for (int k = PLEN - 1; k >= 1; k--) begin
            if (histLen[i] >= k && (histBits[i] & ((1 << k) - 1)) == (PAT >> (PLEN - k)))
                return k;
        end
        return 0;
    endfunction

    function automatic bit matchNext(input int i, input bit x);
        return (histLen[i] + 1 >= PLEN) && ((((histBits[i] << 1) | int'(x)) & 15) == PAT);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            histBits[i] = 0; histLen[i] = 0; cnt[i] = 0; mooreFlag[i] = 0;
        end
    endtask

    task automatic modelStep();
        bit m;
        for (int i = 0; i < 4; i++) begin
            if (clear) begin
                histBits[i] = 0; histLen[i] = 0; cnt[i] = 0; mooreFlag[i] = 0;
            end else if (in_valid) begin
                m = matchNext(i, xin);
                mooreFlag[i] = int'(m);
                if (m && cnt[i] < cntMax[i]) cnt[i]++;
                histBits[i] = ((histBits[i] << 1) | int'(xin)) & 16'hFFFF;
                histLen[i]  = (histLen[i] < 16) ? histLen[i] + 1 : 16;
                if (m && overlapCfg[i] == 0) begin
                    histBits[i] = 0; histLen[i] = 0;
                end
            end else begin
                mooreFlag[i] = 0;
            end
        end
    endtask

    task automatic checkAll();
        int yv [4];
        int sv [4];
        int cv [4];
        int zv [4];
        int expY;
        yv = '{int'(ya), int'(yb), int'(yc), int'(yd)};
        sv = '{int'(sa), int'(sb), int'(sc), int'(sd)};
        cv = '{int'(ca), int'(cb), int'(cc), int'(cd)};
        zv = '{int'(za), int'(zb), int'(zc), int'(zd)};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) expY = mooreFlag[i];
            else        expY = int'(in_valid && !clear && !reset && matchNext(i, xin));
            checkOutput($sformatf("y_out[%0d]", i), yv[i], expY);
            checkOutput($sformatf("new_state[%0d]", i), sv[i], modelProg(i));
            checkOutput($sformatf("match_count[%0d]", i), cv[i], cnt[i]);
            checkOutput($sformatf("count_sat[%0d]", i), zv[i], int'(cnt[i] == cntMax[i]));
        end
    endtask

    // One clock of stimulus: drive after the falling edge, check, then advance the model.
    task automatic applyStimulus(input bit x, input bit v, input bit c);
        @(negedge clk);
        xin = x; in_valid = v; clear = c;
        #1;
        checkAll();
        modelStep();
    endtask

    task automatic applyReset();
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyBits(input string bits);
        for (int i = 0; i < bits.len(); i++) applyStimulus(bits[i] == "1", 1'b1, 1'b0);
    endtask

    initial begin
        $display("[TB] seq_detector_param bench start");
        modelReset();
        applyReset();

        applyBits("1011011");
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) applyStimulus(g[0], 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyBits("101");
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyBits("01");
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyReset();
        applyBits("1011011011011");
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 260; n++) applyBits("011");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) applyReset();
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 40) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
